// File: rtl/conv_8x32_pkg.sv
// conv_8x32_pkg: shared types and default limits for the 8x32 convolution sequencer
package conv_8x32_pkg;
  localparam int IDX_W = 8;
  localparam int MAX_SIG_LEN_DEF = 32;
  localparam int MAX_KER_LEN_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [IDX_W-1:0] x_addr;
    logic [IDX_W-1:0] h_addr;
    logic [IDX_W-1:0] y_addr;
    logic mac_en;
    logic acc_clr;
    logic acc_last;
  } tap_t;
endpackage

// File: rtl/conv_8x32_loop_sequencer_if.sv
// conv_8x32_loop_sequencer_if: host control and tap bus between host, sequencer and MAC datapath
interface conv_8x32_loop_sequencer_if #(parameter int IDX_WIDTH = conv_8x32_pkg::IDX_W);
  logic start_in;
  logic [IDX_WIDTH-1:0] sig_len_in;
  logic [IDX_WIDTH-1:0] ker_len_in;
  logic adv_in;
  logic busy_out;
  logic done_out;
  logic cfg_err_out;
  logic [IDX_WIDTH-1:0] x_addr_out;
  logic [IDX_WIDTH-1:0] h_addr_out;
  logic [IDX_WIDTH-1:0] y_addr_out;
  logic mac_en_out;
  logic acc_clr_out;
  logic acc_last_out;
  modport master (
    output start_in, sig_len_in, ker_len_in, adv_in,
    input busy_out, done_out, cfg_err_out, x_addr_out, h_addr_out, y_addr_out,
          mac_en_out, acc_clr_out, acc_last_out
  );
  modport slave (
    input start_in, sig_len_in, ker_len_in, adv_in,
    output busy_out, done_out, cfg_err_out, x_addr_out, h_addr_out, y_addr_out,
           mac_en_out, acc_clr_out, acc_last_out
  );
endinterface

// File: rtl/conv_8x32_comp_less_or_eq.sv
// conv_8x32_comp_less_or_eq: unsigned a <= b comparator
module conv_8x32_comp_less_or_eq #(parameter int DATA_WIDTH = 8) (
  input logic [DATA_WIDTH-1:0] a,
  input logic [DATA_WIDTH-1:0] b,
  output logic le
);
  assign le = a <= b;
endmodule

// File: rtl/conv_8x32_loop_sequencer.sv
// conv_8x32_loop_sequencer: walks every (n, k) tap of a full 1-D convolution and issues registered tap strobes
module conv_8x32_loop_sequencer
  import conv_8x32_pkg::*;
#(
  parameter int IDX_WIDTH = IDX_W,
  parameter int MAX_SIG_LEN = MAX_SIG_LEN_DEF,
  parameter int MAX_KER_LEN = MAX_KER_LEN_DEF
) (
  input logic clk,
  input logic rst_n,
  conv_8x32_loop_sequencer_if.slave bus
);
  typedef logic [IDX_WIDTH-1:0] idx_t;
  state_t state, state_d;
  idx_t n, k, sl, kl, n_d, k_d, sl_d, kl_d, diff;
  logic busy, done, err, done_d, err_d, tap_on, legal, k_inc, le_kn, le_x, mac;
  tap_t tap, tap_d;
  assign legal = bus.sig_len_in != '0 && bus.sig_len_in <= idx_t'(MAX_SIG_LEN) &&
                 bus.ker_len_in != '0 && bus.ker_len_in <= idx_t'(MAX_KER_LEN);
  conv_8x32_comp_less_or_eq #(.DATA_WIDTH(IDX_WIDTH)) u_kwrap (.a(k + idx_t'(1)), .b(kl - idx_t'(1)), .le(k_inc));
  conv_8x32_comp_less_or_eq #(.DATA_WIDTH(IDX_WIDTH)) u_kn (.a(k_d), .b(n_d), .le(le_kn));
  conv_8x32_comp_less_or_eq #(.DATA_WIDTH(IDX_WIDTH)) u_x (.a(diff), .b(sl_d - idx_t'(1)), .le(le_x));
  // n-k is only formed once k <= n is known, so it never wraps
  assign diff = le_kn ? n_d - k_d : '0;
  assign mac = le_kn && le_x;
  always_comb begin
    state_d = state;
    n_d = n;
    k_d = k;
    sl_d = sl;
    kl_d = kl;
    err_d = err;
    done_d = 1'b0;
    tap_on = 1'b0;
    case (state)
      IDLE: if (bus.start_in) begin
        err_d = !legal;
        if (legal) begin
          state_d = RUN;
          sl_d = bus.sig_len_in;
          kl_d = bus.ker_len_in;
          n_d = '0;
          k_d = '0;
          tap_on = 1'b1;
        end
      end
      RUN: begin
        tap_on = 1'b1;
        if (bus.adv_in) begin
          if (k_inc) k_d = k + idx_t'(1);
          else if (n == sl + kl - idx_t'(2)) begin
            state_d = DONE;
            done_d = 1'b1;
            tap_on = 1'b0;
          end else begin
            n_d = n + idx_t'(1);
            k_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tap_d = '0;
    if (tap_on) tap_d = '{x_addr: mac ? diff : '0, h_addr: k_d, y_addr: n_d, mac_en: mac,
                          acc_clr: k_d == '0, acc_last: k_d == kl_d - idx_t'(1)};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      n <= '0;
      k <= '0;
      sl <= '0;
      kl <= '0;
      tap <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      n <= n_d;
      k <= k_d;
      sl <= sl_d;
      kl <= kl_d;
      tap <= tap_d;
      busy <= state_d == RUN;
      done <= done_d;
      err <= err_d;
    end
  assign bus.busy_out = busy;
  assign bus.done_out = done;
  assign bus.cfg_err_out = err;
  assign bus.x_addr_out = tap.x_addr;
  assign bus.h_addr_out = tap.h_addr;
  assign bus.y_addr_out = tap.y_addr;
  assign bus.mac_en_out = tap.mac_en;
  assign bus.acc_clr_out = tap.acc_clr;
  assign bus.acc_last_out = tap.acc_last;
endmodule

// File: tb/tb_conv_8x32_loop_sequencer.sv
// tb_conv_8x32_loop_sequencer: scoreboard bench comparing every tap against a reference loop nest
module tb_conv_8x32_loop_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  logic [29:0] q[$];
  conv_8x32_loop_sequencer_if bus ();
  conv_8x32_loop_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [29:0] obs();
    return {bus.busy_out, bus.done_out, bus.cfg_err_out, bus.x_addr_out, bus.h_addr_out,
            bus.y_addr_out, bus.mac_en_out, bus.acc_clr_out, bus.acc_last_out};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic start(input int nn, input int mm);
    @(negedge clk);
    bus.sig_len_in = 8'(nn);
    bus.ker_len_in = 8'(mm);
    bus.start_in = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b0;
  endtask
  task automatic run(input int nn, input int mm, input bit tog, input int abort_at);
    int cyc, idx, busy_c, mac_c, last_c, exp_mac;
    bit a, v;
    q.delete();
    exp_mac = 0; busy_c = 0; mac_c = 0; last_c = 0; idx = 0; cyc = 0; a = 1'b0;
    for (int n = 0; n < nn + mm - 1; n++)
      for (int k = 0; k < mm; k++) begin
        v = (k <= n) && (n - k <= nn - 1);
        exp_mac += int'(v);
        q.push_back({3'b100, v ? 8'(n - k) : 8'd0, 8'(k), 8'(n), v, k == 0, k == mm - 1});
      end
    bus.adv_in = 1'b1;
    start(nn, mm);
    while (q.size() != 0 && cyc < 4000) begin
      if (idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst", {2'b0, obs()}, 32'd0);
        repeat (3) begin
          @(negedge clk);
          chk("rst_hold", {2'b0, obs()}, 32'd0);
        end
        rst_n = 1'b1;
        return;
      end
      chk($sformatf("tap%0d_n%0d_m%0d", idx, nn, mm), {2'b0, obs()}, {2'b0, q[0]});
      busy_c += int'(bus.busy_out);
      mac_c += int'(bus.mac_en_out);
      last_c += int'(bus.acc_last_out);
      a = tog ? !a : 1'b1;
      bus.adv_in = a;
      if (a) begin
        void'(q.pop_front());
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("timeout", q.size(), 32'd0);
    chk("done", {2'b0, obs()}, {2'b0, 3'b010, 27'd0});
    @(negedge clk);
    chk("done_fall", {2'b0, obs()}, 32'd0);
    if (!tog) begin
      chk("busy_cycles", busy_c, (nn + mm - 1) * mm);
      chk("mac_cycles", mac_c, exp_mac);
      chk("last_pulses", last_c, nn + mm - 1);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start_in = 1'b0;
    bus.sig_len_in = '0;
    bus.ker_len_in = '0;
    bus.adv_in = 1'b1;
    #1;
    chk("reset", {2'b0, obs()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(4, 2, 1'b0, -1);
    run(32, 8, 1'b0, -1);
    run(1, 1, 1'b0, -1);
    run(4, 2, 1'b1, -1);
    start(4, 0);
    chk("err_m0", {bus.busy_out, bus.cfg_err_out}, 32'd1);
    start(33, 4);
    chk("err_n33", {bus.busy_out, bus.cfg_err_out}, 32'd1);
    start(0, 4);
    chk("err_n0", {bus.busy_out, bus.cfg_err_out}, 32'd1);
    run(4, 2, 1'b0, -1);
    chk("err_cleared", bus.cfg_err_out, 32'd0);
    run(32, 8, 1'b0, 100);
    run(32, 8, 1'b0, -1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
